// File: rtl/capture_controller_if.sv
// Sample-memory write bus for capture_controller.
//   master : drives wr_en / wr_addr / wr_data (the capture controller)
//   slave  : receives the writes (sample memory, monitors)
// Ports (bundled signals):
//   wr_en   - one-cycle write strobe per stored sample
//   wr_addr - write address, 0..SAMPLE_BUFF_SIZE-1
//   wr_data - sample word, bit i = channel i
interface capture_controller_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/capture_controller.sv
// Logic-analyser style capture controller.
// Synchronises the raw channel inputs, divides the clock down to a sample
// tick, waits for a trigger condition on one channel and then streams
// SAMPLE_BUFF_SIZE samples into a sample memory over the write bus.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-low
//   chan_in      - raw asynchronous channel inputs
//   trig_enable  - level: 1 arms/keeps capture, 0 aborts to IDLE
//   trig_mode    - 00 immediate, 01 rising, 10 falling, 11 either edge
//   trig_chan    - channel watched for the trigger edge
//   sample_div   - sample period = sample_div+1 clocks
//   rearm        - single-cycle pulse, leaves DONE
//   wr_bus       - write bus to the sample memory (master side)
//   capture_done - 1 while the buffer holds a complete capture
//   state        - FSM state: IDLE=00, ARMED=01, CAPTURE=10, DONE=11
module capture_controller #(
  parameter int  CHANNEL_COUNT    = 8,
  parameter int  SAMPLE_BUFF_SIZE = 640,
  parameter int  DIV_WIDTH        = 16,
  localparam int SEL_WIDTH        = $clog2(CHANNEL_COUNT),
  localparam int ADDR_WIDTH       = $clog2(SAMPLE_BUFF_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNEL_COUNT-1:0] chan_in,
  input  logic                     trig_enable,
  input  logic [1:0]               trig_mode,
  input  logic [SEL_WIDTH-1:0]     trig_chan,
  input  logic [DIV_WIDTH-1:0]     sample_div,
  input  logic                     rearm,
  capture_controller_if.master     wr_bus,
  output logic                     capture_done,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLE_BUFF_SIZE - 1);

  // Trigger condition on one channel, given its previous and current sample.
  function automatic logic trig_hit_f(input logic [1:0] mode,
                                      input logic       prev_bit,
                                      input logic       cur_bit);
    logic hit;
    case (mode)
      2'b00:   hit = 1'b1;
      2'b01:   hit = ~prev_bit & cur_bit;
      2'b10:   hit = prev_bit & ~cur_bit;
      2'b11:   hit = prev_bit ^ cur_bit;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  logic [CHANNEL_COUNT-1:0] sync_meta_r;
  logic [CHANNEL_COUNT-1:0] sample_r;
  logic [CHANNEL_COUNT-1:0] prev_sample_r;
  logic [DIV_WIDTH-1:0]     div_cnt_r;
  state_t                   state_r;
  logic                     wr_en_r;
  logic [ADDR_WIDTH-1:0]    wr_addr_r;
  logic [CHANNEL_COUNT-1:0] wr_data_r;
  logic                     capture_done_r;

  logic                     tick_s;
  logic                     hit_s;
  logic                     arm_s;
  logic [ADDR_WIDTH-1:0]    next_addr_s;

  // Sample tick, trigger detection and next write address.
  always_comb begin
    tick_s      = (div_cnt_r == sample_div);
    hit_s       = trig_hit_f(trig_mode, prev_sample_r[trig_chan], sample_r[trig_chan]);
    arm_s       = (state_r == ST_IDLE) && trig_enable;
    next_addr_s = wr_addr_r + ADDR_WIDTH'(1);
  end

  // Two-flop synchroniser for the asynchronous channel inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_r <= '0;
      sample_r    <= '0;
    end else begin
      sync_meta_r <= chan_in;
      sample_r    <= sync_meta_r;
    end
  end

  // Free-running sample divider (restarted on arming) and edge-history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r     <= '0;
      prev_sample_r <= '0;
    end else begin
      if (arm_s || tick_s) begin
        div_cnt_r <= '0;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
      end
      // The edge history follows the tick in every state, so the first
      // armed tick compares against a real previous sample.
      if (tick_s) begin
        prev_sample_r <= sample_r;
      end else begin
        prev_sample_r <= prev_sample_r;
      end
    end
  end

  // Capture FSM with registered write bus and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      wr_en_r        <= 1'b0;
      wr_addr_r      <= '0;
      wr_data_r      <= '0;
      capture_done_r <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (trig_enable) begin
            state_r <= ST_ARMED;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          // Abort has priority over a trigger hit in the same cycle.
          if (!trig_enable) begin
            state_r   <= ST_IDLE;
            wr_addr_r <= '0;
          end else if (tick_s && hit_s) begin
            wr_en_r        <= 1'b1;
            wr_addr_r      <= '0;
            wr_data_r      <= sample_r;
            state_r        <= (LAST_ADDR == '0) ? ST_DONE : ST_CAPTURE;
            capture_done_r <= (LAST_ADDR == '0);
          end else begin
            state_r <= ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (!trig_enable) begin
            state_r   <= ST_IDLE;
            wr_addr_r <= '0;
          end else if (tick_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= next_addr_s;
            wr_data_r <= sample_r;
            // Stop right after the last address; the address never wraps.
            if (next_addr_s == LAST_ADDR) begin
              state_r        <= ST_DONE;
              capture_done_r <= 1'b1;
            end else begin
              state_r <= ST_CAPTURE;
            end
          end else begin
            state_r <= ST_CAPTURE;
          end
        end
        ST_DONE: begin
          // Only rearm leaves DONE; trig_enable is ignored here.
          if (rearm) begin
            state_r        <= ST_IDLE;
            capture_done_r <= 1'b0;
            wr_addr_r      <= '0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          capture_done_r <= 1'b0;
          wr_addr_r      <= '0;
        end
      endcase
    end
  end

  assign wr_bus.wr_en   = wr_en_r;
  assign wr_bus.wr_addr = wr_addr_r;
  assign wr_bus.wr_data = wr_data_r;
  assign capture_done   = capture_done_r;
  assign state          = state_r;

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: a table of short directed
// steps for the state machine, followed by full-capture sequences, abort,
// DONE/rearm handling and an asynchronous mid-capture reset.
module tb_capture_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  chan_in = 8'h00;
  logic        trig_enable = 1'b0;
  logic [1:0]  trig_mode = 2'b00;
  logic [2:0]  trig_chan = 3'd3;
  logic [15:0] sample_div = 16'd0;
  logic        rearm = 1'b0;
  logic        capture_done;
  logic [1:0]  state;

  capture_controller_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();

  capture_controller #(
    .CHANNEL_COUNT(8),
    .SAMPLE_BUFF_SIZE(640),
    .DIV_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chan_in(chan_in),
    .trig_enable(trig_enable),
    .trig_mode(trig_mode),
    .trig_chan(trig_chan),
    .sample_div(sample_div),
    .rearm(rearm),
    .wr_bus(bus),
    .capture_done(capture_done),
    .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int wr_count = 0;
  // write monitor controls
  logic       mon_on = 1'b0;
  int         mon_next_addr = 0;
  int         mon_last_cyc = 0;
  int         mon_period = 0;
  logic [7:0] mon_exp_data = 8'h00;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] ci;
    logic       rr;
    int         cyc;
    logic [1:0] st;
    logic       dn;
    logic       we;
    logic [9:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    trig_enable = 1'b0;
    rearm = 1'b0;
    step(2);
    wr_count = 0;
    mon_on = 1'b0;
    reset = 1'b1;
    step(1);
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (wr_count < target && n < budget) begin
      step(1);
      n++;
    end
    check(name, wr_count >= target, 1);
  endtask

  task automatic arm_monitor(input logic [7:0] data, input int period);
    mon_next_addr = 0;
    mon_exp_data = data;
    mon_period = period;
    mon_on = 1'b1;
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // write monitor: address order, data and spacing of every write
  initial forever begin
    @(negedge clk);
    if (bus.wr_en === 1'b1) begin
      if (mon_on) begin
        check("wr_addr", bus.wr_addr, mon_next_addr);
        check("wr_data", bus.wr_data, mon_exp_data);
        if (mon_period != 0 && mon_next_addr != 0)
          check("wr_spacing", cyc_cnt - mon_last_cyc, mon_period);
      end
      mon_next_addr++;
      mon_last_cyc = cyc_cnt;
      wr_count++;
    end
  end

  initial begin
    int base;
    // en mode ci rearm cycles | state done wr_en addr data
    vecs[0]  = '{1'b0, 2'b00, 8'h00, 1'b0, 2, 2'b00, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[1]  = '{1'b1, 2'b01, 8'h00, 1'b0, 1, 2'b01, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[2]  = '{1'b1, 2'b01, 8'h00, 1'b1, 1, 2'b01, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[3]  = '{1'b1, 2'b10, 8'h00, 1'b0, 3, 2'b01, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[4]  = '{1'b1, 2'b01, 8'h08, 1'b0, 2, 2'b01, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[5]  = '{1'b1, 2'b01, 8'h08, 1'b0, 1, 2'b10, 1'b0, 1'b1, 10'd0, 8'h08};
    vecs[6]  = '{1'b1, 2'b01, 8'h08, 1'b0, 1, 2'b10, 1'b0, 1'b1, 10'd1, 8'h08};
    vecs[7]  = '{1'b0, 2'b01, 8'h08, 1'b0, 1, 2'b00, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[8]  = '{1'b1, 2'b00, 8'h08, 1'b0, 1, 2'b01, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[9]  = '{1'b0, 2'b00, 8'h08, 1'b0, 1, 2'b00, 1'b0, 1'b0, 10'd0, 8'h00};
    vecs[10] = '{1'b1, 2'b00, 8'h08, 1'b0, 2, 2'b10, 1'b0, 1'b1, 10'd0, 8'h08};
    vecs[11] = '{1'b0, 2'b00, 8'h08, 1'b0, 1, 2'b00, 1'b0, 1'b0, 10'd0, 8'h00};

    // reset values while reset is held, before any clock edge
    #1 reset = 1'b0;
    #1;
    check("rst_state", state, 2'b00);
    check("rst_done", capture_done, 1'b0);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 10'd0);
    check("rst_wr_data", bus.wr_data, 8'h00);
    step(2);
    reset = 1'b1;
    step(1);

    // table-driven state machine steps (sample_div=0, trig_chan=3)
    for (int i = 0; i < 12; i++) begin
      trig_enable = vecs[i].en;
      trig_mode   = vecs[i].mode;
      chan_in     = vecs[i].ci;
      rearm       = vecs[i].rr;
      step(vecs[i].cyc);
      check($sformatf("vec%0d_state", i), state, vecs[i].st);
      check($sformatf("vec%0d_done", i), capture_done, vecs[i].dn);
      check($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].we);
      check($sformatf("vec%0d_wr_addr", i), bus.wr_addr, vecs[i].addr);
      if (vecs[i].we)
        check($sformatf("vec%0d_wr_data", i), bus.wr_data, vecs[i].data);
    end
    rearm = 1'b0;

    // immediate mode, every clock, static A5: full capture
    do_reset();
    trig_mode = 2'b00; sample_div = 16'd0; chan_in = 8'hA5;
    step(3);
    arm_monitor(8'hA5, 1);
    trig_enable = 1'b1;
    wait_writes(640, 1000, "imm_capture_timeout");
    check("imm_state_done", state, 2'b11);
    check("imm_capture_done", capture_done, 1'b1);
    step(5);
    check("imm_write_count", wr_count, 640);
    check("imm_state_hold", state, 2'b11);

    // rising edge on ch3 after 100 clocks, sample_div=3
    do_reset();
    trig_mode = 2'b01; trig_chan = 3'd3; sample_div = 16'd3; chan_in = 8'h41;
    step(3);
    arm_monitor(8'h49, 4);
    trig_enable = 1'b1;
    step(100);
    check("rise_no_early_write", wr_count, 0);
    chan_in = 8'h49;
    wait_writes(640, 3000, "rise_capture_timeout");
    check("rise_state_done", state, 2'b11);
    check("rise_capture_done", capture_done, 1'b1);

    // falling mode with ch3 held high: stays armed; then falling edge
    do_reset();
    trig_mode = 2'b10; sample_div = 16'd1; chan_in = 8'h08;
    step(3);
    trig_enable = 1'b1;
    step(50);
    check("fall_armed_state", state, 2'b01);
    check("fall_no_write", wr_count, 0);
    arm_monitor(8'h00, 2);
    chan_in = 8'h00;
    wait_writes(201, 1000, "fall_capture_timeout");
    // abort after the write at address 200
    trig_enable = 1'b0;
    step(1);
    check("abort_state", state, 2'b00);
    check("abort_done", capture_done, 1'b0);
    check("abort_wr_en", bus.wr_en, 1'b0);
    check("abort_wr_addr", bus.wr_addr, 10'd0);
    step(10);
    check("abort_write_count", wr_count, 201);
    // re-enable: new capture from address 0
    trig_mode = 2'b00; sample_div = 16'd0;
    arm_monitor(8'h00, 1);
    trig_enable = 1'b1;
    wait_writes(841, 1500, "recap_timeout");
    check("recap_state_done", state, 2'b11);
    check("recap_capture_done", capture_done, 1'b1);

    // DONE ignores trig_enable; only rearm leaves it
    trig_enable = 1'b0;
    step(3);
    check("done_en0_state", state, 2'b11);
    check("done_en0_done", capture_done, 1'b1);
    trig_enable = 1'b1;
    step(2);
    check("done_en1_state", state, 2'b11);
    trig_mode = 2'b01;
    rearm = 1'b1;
    step(1);
    rearm = 1'b0;
    check("rearm_state_idle", state, 2'b00);
    check("rearm_done_clear", capture_done, 1'b0);
    step(1);
    check("rearm_state_armed", state, 2'b01);
    rearm = 1'b1;
    step(1);
    rearm = 1'b0;
    check("rearm_ignored_armed", state, 2'b01);
    check("done_no_writes", wr_count, 841);

    // asynchronous reset in the middle of a capture
    base = wr_count;
    arm_monitor(8'h00, 1);
    trig_mode = 2'b00;
    wait_writes(base + 10, 100, "midcap_timeout");
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", state, 2'b00);
    check("async_rst_wr_en", bus.wr_en, 1'b0);
    check("async_rst_wr_addr", bus.wr_addr, 10'd0);
    check("async_rst_wr_data", bus.wr_data, 8'h00);
    check("async_rst_done", capture_done, 1'b0);
    base = wr_count;
    trig_enable = 1'b0;
    step(3);
    reset = 1'b1;
    step(20);
    check("post_rst_no_write", wr_count, base);
    check("post_rst_state", state, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_controller.md
CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Parameters
REQ-001 CHANNEL_COUNT, 8, number of sampled channels.
REQ-002 SAMPLE_BUFF_SIZE, 640, samples per capture (one per display column).
REQ-003 DIV_WIDTH, 16, width of sample-rate divider.

Interface
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset asserted); one clock domain, no other clocks.
REQ-006 chan_in  input  CHANNEL_COUNT  raw asynchronous channel inputs.
REQ-007 trig_enable  input  1  level; 1 = arm/keep capture, 0 = abort to IDLE.
REQ-008 trig_mode  input  2  00 immediate, 01 rising, 10 falling, 11 either edge.
REQ-009 trig_chan  input  clog2(CHANNEL_COUNT)  channel watched for trigger edge.
REQ-010 sample_div  input  DIV_WIDTH  sample period = sample_div+1 clocks.
REQ-011 rearm  input  1  single-cycle pulse; leaves DONE.
REQ-012 wr_en  output  1  sample-memory write strobe, one cycle per sample.
REQ-013 wr_addr  output  clog2(SAMPLE_BUFF_SIZE)  sample-memory write address.
REQ-014 wr_data  output  CHANNEL_COUNT  sample word, bit i = channel i.
REQ-015 capture_done  output  1  level; 1 while buffer holds a complete capture.
REQ-016 state  output  2  current FSM state encoding.

Function
REQ-017 chan_in SHALL pass through a 2-flop synchronizer; "sample" denotes the second-stage value.
REQ-018 Divider counter SHALL count 0..sample_div, wrap to 0, and assert internal tick in the cycle count==sample_div; sample_div=0 SHALL tick every clock.
REQ-019 Divider SHALL be cleared to 0 on the IDLE->ARMED transition; otherwise free-running.
REQ-020 On every tick, in every state, the SHALL register prev_sample <= sample.
REQ-021 Trigger hit at a tick: mode 00 always; 01 prev[trig_chan]=0 & sample[trig_chan]=1; 10 the inverse; 11 either.
REQ-022 FSM states: IDLE=00, ARMED=01, CAPTURE=10, DONE=11.
REQ-023 IDLE->ARMED on the clock where trig_enable=1.
REQ-024 ARMED->CAPTURE on a tick with trigger hit; that tick's sample SHALL be written at wr_addr 0.
REQ-025 CAPTURE: each tick writes sample at next address (+1); after write at SAMPLE_BUFF_SIZE-1 SHALL go DONE; no address wrap.
REQ-026 wr_en/wr_addr/wr_data SHALL be registered: asserted in cycle following the qualifying tick, wr_en high exactly one cycle.
REQ-027 Exactly SAMPLE_BUFF_SIZE writes per capture, addresses 0..SAMPLE_BUFF_SIZE-1 in order.
REQ-028 DONE: no writes; capture_done=1; rearm=1 -> IDLE (then ARMED next cycle if trig_enable=1).
REQ-029 trig_enable=0 in ARMED or CAPTURE SHALL abort to IDLE next cycle, write address to 0, no further writes; capture_done stays 0.
REQ-030 trig_enable=0 in DONE SHALL NOT leave DONE; only rearm leaves DONE.
REQ-031 rearm outside DONE SHALL be ignored.
REQ-032 Trigger hit and trig_enable=0 same cycle: abort wins, no write.
REQ-033 capture_done SHALL clear on the DONE->IDLE transition.

Reset
REQ-034 reset=0 SHALL immediately force: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, capture_done=0, divider=0, prev_sample=0, synchronizer=0.
REQ-035 Reset mid-CAPTURE SHALL discard capture; after release FSM restarts from IDLE.

Verification
REQ-036 mode 00, sample_div=0, trig_enable=1, chan_in=8'hA5 static -> 640 consecutive wr_en pulses, addr 0..639, data 8'hA5, then capture_done=1, state=11.
REQ-037 mode 01, trig_chan=3, sample_div=3, ch3 rises at clock 100 -> first write data[3]=1 at addr 0; successive writes spaced exactly 4 clocks.
REQ-038 mode 10, ch3 held high, no edge -> state stays 01, wr_en never asserts; then falling edge -> capture starts, addr 0 data[3]=0.
REQ-039 trig_enable dropped after write addr 200 -> no further writes, state=00 next cycle, capture_done=0; re-enable -> next capture starts at addr 0.
REQ-040 In DONE: trig_enable toggled -> state stays 11; rearm pulse -> state 00, capture_done=0, then 01.
REQ-041 reset=0 asserted mid-capture asynchronously (between clock edges) -> outputs zero immediately, no wr_en after release until new trigger.
